// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipeline_pkg
// Description : Shared types and constants for the pipeline hazard controller.
//               - state_e : hazard-sequencing FSM states
//               - FWD_*   : operand forward select codes
//               - REG_PC  : register index of the PC (never forwarded)
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [3:0] REG_PC = 4'hF;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
`default_nettype none
// ============================================================================
// Module      : forward_sel
// Description : Combinational forward-source picker for one ID operand.
//               Nearest producing stage wins: EX > MEM > WB, else RF.
// Ports       : src        - source register index read in ID
//               src_used   - ID instruction actually reads src
//               ex_rd/ex_fwd_en, mem_rd/mem_fwd_en, wb_rd/wb_fwd_en
//                          - destination and forwardable flag per stage
//               sel        - FWD_RF / FWD_EX / FWD_MEM / FWD_WB
// Revision    : 1.0 - initial release
// ============================================================================
module forward_sel
  import pipeline_pkg::*;
(
  input  logic [3:0] src,
  input  logic       src_used,
  input  logic [3:0] ex_rd,
  input  logic       ex_fwd_en,
  input  logic [3:0] mem_rd,
  input  logic       mem_fwd_en,
  input  logic [3:0] wb_rd,
  input  logic       wb_fwd_en,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    // The PC is read from the PC path, never from a bypass.
    if (src_used && (src != REG_PC)) begin
      if (ex_fwd_en && (ex_rd == src)) begin
        sel = FWD_EX;
      end else if (mem_fwd_en && (mem_rd == src)) begin
        sel = FWD_MEM;
      end else if (wb_fwd_en && (wb_rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall / flush / forwarding controller for the 5-stage
//               pipeline. Mealy outputs act on a hazard in the cycle it is
//               detected; the FSM only remembers what was done last cycle.
// Ports       : clk, R (sync, active-low reset)
//               id_instr, id_uses_rn, id_uses_rm    - ID operand info
//               ex/mem/wb_rd, ex/mem/wb_rf_en       - stage destinations
//               ex_load_instr, ex_branch_taken      - EX hazard sources
//               mem_access, mem_ready               - data memory handshake
//               pc_le, ifid_le, cu_bubble, ifid_flush, pipe_freeze
//               fwd_a, fwd_b                        - Rn / Rm forward selects
//               mem_timeout                         - sticky wait timeout
//               stall_count, flush_count            - saturating counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             R,
  input  logic [31:0]      id_instr,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [3:0]       ex_rd,
  input  logic [3:0]       mem_rd,
  input  logic [3:0]       wb_rd,
  input  logic             ex_rf_en,
  input  logic             mem_rf_en,
  input  logic             wb_rf_en,
  input  logic             ex_load_instr,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             cu_bubble,
  output logic             ifid_flush,
  output logic             pipe_freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int                WCNT_W     = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_MAX);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [3:0] w_rn;
  logic [3:0] w_rm;
  logic       w_mem_stall;
  logic       w_load_use;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_unused_instr_bits;

  assign w_rn = id_instr[19:16];
  assign w_rm = id_instr[3:0];
  assign w_unused_instr_bits = ^{id_instr[31:20], id_instr[15:4]};

  assign w_mem_stall = mem_access & ~mem_ready;
  assign w_load_use  = ex_load_instr & ex_rf_en &
                       ((id_uses_rn & (ex_rd == w_rn)) |
                        (id_uses_rm & (ex_rd == w_rm)));

  // --------------------------------------------------------------------------
  // Next state, counters and Mealy control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = RUN;
    pc_le       = 1'b1;
    ifid_le     = 1'b1;
    cu_bubble   = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (w_mem_stall) begin
      pc_le       = 1'b0;
      ifid_le     = 1'b0;
      pipe_freeze = 1'b1;
      state_d     = MEM_WAIT;
      wait_cnt_d  = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q
                                               : wait_cnt_q + WCNT_W'(1);
    end else if (ex_branch_taken && (state_q != BR_FLUSH)) begin
      // Squashing the ID instruction also cancels any load-use it caused.
      cu_bubble  = 1'b1;
      ifid_flush = 1'b1;
      state_d    = BR_FLUSH;
      if (flush_cnt_q != '1) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end else if (w_load_use && (state_q != LD_STALL)) begin
      // One bubble suffices: next cycle the load sits in MEM and forwards.
      pc_le     = 1'b0;
      ifid_le   = 1'b0;
      cu_bubble = 1'b1;
      state_d   = LD_STALL;
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end

    if (wait_cnt_d == WAIT_LIMIT) begin
      timeout_d = 1'b1;
    end

    if (!R) begin
      pc_le       = 1'b0;
      ifid_le     = 1'b0;
      cu_bubble   = 1'b1;
      ifid_flush  = 1'b1;
      pipe_freeze = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!R) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Operand forwarding; a load still in EX has no data to bypass yet.
  // --------------------------------------------------------------------------
  forward_sel u_fwd_rn (
    .src        (w_rn),
    .src_used   (id_uses_rn),
    .ex_rd      (ex_rd),
    .ex_fwd_en  (ex_rf_en & ~ex_load_instr),
    .mem_rd     (mem_rd),
    .mem_fwd_en (mem_rf_en),
    .wb_rd      (wb_rd),
    .wb_fwd_en  (wb_rf_en),
    .sel        (w_fwd_a)
  );

  forward_sel u_fwd_rm (
    .src        (w_rm),
    .src_used   (id_uses_rm),
    .ex_rd      (ex_rd),
    .ex_fwd_en  (ex_rf_en & ~ex_load_instr),
    .mem_rd     (mem_rd),
    .mem_fwd_en (mem_rf_en),
    .wb_rd      (wb_rd),
    .wb_fwd_en  (wb_rf_en),
    .sel        (w_fwd_b)
  );

  assign fwd_a       = R ? w_fwd_a : FWD_RF;
  assign fwd_b       = R ? w_fwd_b : FWD_RF;
  assign mem_timeout = timeout_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed plus random stimulus for pipeline_hazard_ctrl,
//               compared against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             R;
  logic [31:0]      id_instr;
  logic             id_uses_rn, id_uses_rm;
  logic [3:0]       ex_rd, mem_rd, wb_rd;
  logic             ex_rf_en, mem_rf_en, wb_rf_en;
  logic             ex_load_instr, ex_branch_taken;
  logic             mem_access, mem_ready;
  logic             pc_le, ifid_le, cu_bubble, ifid_flush, pipe_freeze;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;

  pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .R               (R),
    .id_instr        (id_instr),
    .id_uses_rn      (id_uses_rn),
    .id_uses_rm      (id_uses_rm),
    .ex_rd           (ex_rd),
    .mem_rd          (mem_rd),
    .wb_rd           (wb_rd),
    .ex_rf_en        (ex_rf_en),
    .mem_rf_en       (mem_rf_en),
    .wb_rf_en        (wb_rf_en),
    .ex_load_instr   (ex_load_instr),
    .ex_branch_taken (ex_branch_taken),
    .mem_access      (mem_access),
    .mem_ready       (mem_ready),
    .pc_le           (pc_le),
    .ifid_le         (ifid_le),
    .cu_bubble       (cu_bubble),
    .ifid_flush      (ifid_flush),
    .pipe_freeze     (pipe_freeze),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: what happened last cycle, event counts, wait run length.
  bit m_valid    = 0;
  bit m_prev_ld  = 0;
  bit m_prev_br  = 0;
  int m_stall    = 0;
  int m_flush    = 0;
  int m_wait     = 0;
  bit m_timeout  = 0;
  int k_now      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 reset, 1 memory stall, 2 branch flush, 3 load-use stall, 4 normal run
  function automatic int classify();
    logic lu;
    lu = ex_load_instr && ex_rf_en &&
         ((id_uses_rn && ex_rd == id_instr[19:16]) || (id_uses_rm && ex_rd == id_instr[3:0]));
    if (!R) return 0;
    if (mem_access && !mem_ready) return 1;
    if (ex_branch_taken && !m_prev_br) return 2;
    if (lu && !m_prev_ld) return 3;
    return 4;
  endfunction

  function automatic logic [1:0] fwd_model(input logic used, input logic [3:0] r);
    if (!R || !used || r == 4'd15) return 2'b00;
    if (ex_rf_en && !ex_load_instr && ex_rd == r) return 2'b01;
    if (mem_rf_en && mem_rd == r) return 2'b10;
    if (wb_rf_en && wb_rd == r) return 2'b11;
    return 2'b00;
  endfunction

  // Called at posedge+1; samples mid-cycle and compares against the model.
  task automatic eval();
    logic [4:0] e;
    #4;
    k_now = classify();
    case (k_now)
      0:       e = 5'b00110;   // {pc_le, ifid_le, cu_bubble, ifid_flush, pipe_freeze}
      1:       e = 5'b00001;
      2:       e = 5'b11110;
      3:       e = 5'b00100;
      default: e = 5'b11000;
    endcase
    check("pc_le",       pc_le,       e[4]);
    check("ifid_le",     ifid_le,     e[3]);
    check("cu_bubble",   cu_bubble,   e[2]);
    check("ifid_flush",  ifid_flush,  e[1]);
    check("pipe_freeze", pipe_freeze, e[0]);
    check("fwd_a", fwd_a, fwd_model(id_uses_rn, id_instr[19:16]));
    check("fwd_b", fwd_b, fwd_model(id_uses_rm, id_instr[3:0]));
    if (m_valid) begin
      check("stall_count", stall_count, m_stall);
      check("flush_count", flush_count, m_flush);
      check("mem_timeout", mem_timeout, m_timeout);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (k_now == 0) begin
      m_valid = 1; m_prev_ld = 0; m_prev_br = 0;
      m_stall = 0; m_flush = 0; m_wait = 0; m_timeout = 0;
    end else begin
      m_prev_ld = (k_now == 3);
      m_prev_br = (k_now == 2);
      if (k_now == 3 && m_stall < CNT_MAX) m_stall++;
      if (k_now == 2 && m_flush < CNT_MAX) m_flush++;
      if (k_now == 1) m_wait = (m_wait < 1000) ? m_wait + 1 : m_wait;
      else            m_wait = 0;
      if (m_wait >= WAIT_MAX) m_timeout = 1;
    end
    #1;
  endtask

  task automatic idle();
    R = 1'b1; id_instr = 32'h0; id_uses_rn = 0; id_uses_rm = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_rf_en = 0; mem_rf_en = 0; wb_rf_en = 0;
    ex_load_instr = 0; ex_branch_taken = 0; mem_access = 0; mem_ready = 1;
  endtask

  task automatic set_load_use();
    ex_load_instr = 1; ex_rf_en = 1; ex_rd = 4'd3;
    id_instr = 32'h0003_0000; id_uses_rn = 1;
  endtask

  function automatic logic [3:0] rand_reg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 4'd15 : 4'(v);
  endfunction

  initial begin
    int burst;
    idle();
    R = 1'b0;
    @(posedge clk);
    #1;

    // Reset for two cycles
    eval();
    check("rst_pc_le", pc_le, 1'b0);
    check("rst_bubble", cu_bubble, 1'b1);
    check("rst_flush", ifid_flush, 1'b1);
    tick();
    eval();
    check("rst_stall_cnt", stall_count, 0);
    check("rst_flush_cnt", flush_count, 0);
    tick();

    // Release
    idle();
    eval();
    check("run_pc_le", pc_le, 1'b1);
    check("run_ifid_le", ifid_le, 1'b1);
    check("run_bubble", cu_bubble, 1'b0);
    tick();

    // Load-use, then the load forwards from MEM
    set_load_use();
    eval();
    check("lu_pc_le", pc_le, 1'b0);
    check("lu_ifid_le", ifid_le, 1'b0);
    check("lu_bubble", cu_bubble, 1'b1);
    tick();
    check("lu_stall_cnt", stall_count, 1);
    ex_load_instr = 0; ex_rf_en = 0; ex_rd = 0; mem_rd = 4'd3; mem_rf_en = 1;
    eval();
    check("lu_fwd_a_mem", fwd_a, 2'b10);
    check("lu_pc_le_after", pc_le, 1'b1);
    tick();

    // Branch with coincident load-use
    idle(); set_load_use(); ex_branch_taken = 1;
    eval();
    check("br_flush", ifid_flush, 1'b1);
    check("br_bubble", cu_bubble, 1'b1);
    check("br_pc_le", pc_le, 1'b1);
    tick();
    idle();
    eval();
    check("br_flush_cnt", flush_count, 1);
    check("br_stall_cnt", stall_count, 1);
    tick();

    // Memory wait 3 cycles then ready
    mem_access = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      eval();
      check("mw_freeze", pipe_freeze, 1'b1);
      check("mw_pc_le", pc_le, 1'b0);
      tick();
    end
    mem_ready = 1;
    eval();
    check("mw_release_freeze", pipe_freeze, 1'b0);
    check("mw_release_pc_le", pc_le, 1'b1);
    check("mw_no_timeout", mem_timeout, 1'b0);
    tick();

    // Timeout: 20 stalled cycles
    mem_ready = 0;
    for (int i = 0; i < 20; i++) begin
      eval();
      check("to_level", mem_timeout, (i >= WAIT_MAX) ? 1'b1 : 1'b0);
      check("to_freeze", pipe_freeze, 1'b1);
      tick();
    end
    mem_ready = 1;
    eval();
    check("to_sticky", mem_timeout, 1'b1);
    check("to_release_freeze", pipe_freeze, 1'b0);
    tick();
    mem_access = 0;
    eval();
    check("to_sticky2", mem_timeout, 1'b1);
    tick();
    R = 0;
    eval();
    tick();
    R = 1;
    eval();
    check("to_cleared", mem_timeout, 1'b0);
    tick();

    // Forward priority
    idle();
    ex_rd = 4'd5; mem_rd = 4'd5; wb_rd = 4'd5;
    ex_rf_en = 1; mem_rf_en = 1; wb_rf_en = 1;
    id_instr = 32'h0000_0005; id_uses_rm = 1;
    eval();
    check("fwd_b_ex", fwd_b, 2'b01);
    tick();
    ex_rf_en = 0;
    eval();
    check("fwd_b_mem", fwd_b, 2'b10);
    tick();
    ex_rf_en = 1; ex_rd = 4'd15; mem_rd = 4'd15; wb_rd = 4'd15; id_instr = 32'h0000_000F;
    eval();
    check("fwd_b_pc", fwd_b, 2'b00);
    tick();
    ex_rd = 4'd5; id_instr = 32'h0000_0005; id_uses_rm = 0;
    eval();
    check("fwd_b_unused", fwd_b, 2'b00);
    tick();

    // Stall counter saturation
    for (int i = 0; i < 20; i++) begin
      idle(); set_load_use();
      eval(); tick();
      idle();
      eval(); tick();
    end
    check("stall_cnt_sat", stall_count, CNT_MAX);

    // Random traffic
    burst = 0;
    for (int i = 0; i < 800; i++) begin
      R               = ($urandom_range(0, 59) != 0);
      id_instr        = $urandom;
      id_instr[19:16] = rand_reg();
      id_instr[3:0]   = rand_reg();
      id_uses_rn      = $urandom_range(0, 3) != 0;
      id_uses_rm      = $urandom_range(0, 1) != 0;
      ex_rd           = rand_reg();
      mem_rd          = rand_reg();
      wb_rd           = rand_reg();
      ex_rf_en        = $urandom_range(0, 3) != 0;
      mem_rf_en       = $urandom_range(0, 1) != 0;
      wb_rf_en        = $urandom_range(0, 1) != 0;
      ex_load_instr   = $urandom_range(0, 2) == 0;
      ex_branch_taken = $urandom_range(0, 4) == 0;
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(10, 18);
      if (burst > 0) begin
        mem_access = 1; mem_ready = 0; burst--;
      end else begin
        mem_access = $urandom_range(0, 2) == 0;
        mem_ready  = $urandom_range(0, 3) != 0;
      end
      eval();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
